// File: rtl/dmux4way16_buf.sv
// Buffered 4-way word demultiplexer: each word is steered by sel into one of four
// first-word-fall-through FIFOs, and each FIFO drains through its own valid/ready handshake.
module dmux4way16_buf #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [3:0]       full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] w_head [4];
  logic [3:0]       w_push;
  logic [3:0]       w_pop;

  // Refusal is based only on registered full flags, so a pop never opens a slot in the same cycle.
  assign in_ready = !full[sel];

  for (genvar g = 0; g < 4; g++) begin : g_chan
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_cnt;

    assign full[g]      = (r_cnt == CNT_W'(DEPTH));
    assign out_valid[g] = (r_cnt != '0);
    assign w_push[g]    = in_valid && in_ready && (sel == 2'(g));
    assign w_pop[g]     = out_valid[g] && out_ready[g];
    assign w_head[g]    = out_valid[g] ? r_mem[r_rptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_cnt  <= '0;
      end else begin
        if (w_push[g]) r_wptr <= r_wptr + 1'b1;
        if (w_pop[g])  r_rptr <= r_rptr + 1'b1;
        case ({w_push[g], w_pop[g]})
          2'b10:   r_cnt <= r_cnt + 1'b1;
          2'b01:   r_cnt <= r_cnt - 1'b1;
          default: r_cnt <= r_cnt;
        endcase
      end
    end

    // Storage carries no reset; stale entries are masked by the head-valid gating above.
    always_ff @(posedge clk) begin
      if (w_push[g]) r_mem[r_wptr] <= in;
    end
  end

  assign a = w_head[0];
  assign b = w_head[1];
  assign c = w_head[2];
  assign d = w_head[3];

endmodule
